// File: rtl/bubble_timing_generator.sv
// Bubble timing front end: synchronises host strobes, divides master_clock into bubble cycles
// and flags each data bit. Optional watchdog output is built when BUBBLE_TIMING_WATCHDOG_EN is defined.
module bubble_timing_generator #(
    parameter int CYCLE_CLKS   = 500,
    parameter int REP_MIN_CLKS = 200,
    parameter int DATA_OFFSET  = 16,
    parameter int PAGE_CYCLES  = 584,
    parameter int BOOT_CYCLES  = 4096,
    parameter int POS_W        = 13
) (
    input  logic             master_clock,
    input  logic             reset,
    input  logic             bubble_shift_enable,
    input  logic             replicator_enable,
    input  logic             bootloop_enable,
    output logic             bit_strobe,
    output logic [POS_W-1:0] position,
    output logic             page_start,
    output logic             page_done,
    output logic             boot_mode,
    output logic             access_active
`ifdef BUBBLE_TIMING_WATCHDOG_EN
    ,
    output logic             timing_error
`endif
);

    localparam int DIV_W = $clog2(CYCLE_CLKS);
    localparam int REP_W = $clog2(REP_MIN_CLKS + 1);
    localparam int OFF_W = $clog2(DATA_OFFSET + 1);

    typedef enum logic [2:0] {IDLE, BOOT_RUN, USER_WAIT, REP, USER_RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         shift_sync_q, shift_sync_d;
    logic [1:0]         rep_sync_q, rep_sync_d;
    logic [1:0]         boot_sync_q, boot_sync_d;
    logic [DIV_W-1:0]   clk_div_q, clk_div_d;
    logic [POS_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
    logic               bit_strobe_q, bit_strobe_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic               page_start_q, page_start_d;
    logic               page_done_q, page_done_d;
    logic               boot_mode_q, boot_mode_d;
    logic               access_active_q, access_active_d;

    logic shift_low, rep_low, boot_low, tick, pre_tick;

    assign shift_low = !shift_sync_q[1];
    assign rep_low   = !rep_sync_q[1];
    assign boot_low  = !boot_sync_q[1];
    assign tick      = (clk_div_q == DIV_W'(CYCLE_CLKS - 1));
    assign pre_tick  = (clk_div_q == DIV_W'(CYCLE_CLKS - 2));

    always_comb begin
        shift_sync_d    = {shift_sync_q[0], bubble_shift_enable};
        rep_sync_d      = {rep_sync_q[0], replicator_enable};
        boot_sync_d     = {boot_sync_q[0], bootloop_enable};
        state_d         = state_q;
        clk_div_d       = tick ? '0 : clk_div_q + DIV_W'(1);
        bit_cnt_d       = bit_cnt_q;
        rep_cnt_d       = rep_cnt_q;
        off_cnt_d       = off_cnt_q;
        bit_strobe_d    = 1'b0;
        position_d      = position_q;
        page_start_d    = 1'b0;
        page_done_d     = 1'b0;
        boot_mode_d     = boot_mode_q;

        // Shift release aborts any access and suppresses a strobe due this cycle.
        if (state_q != IDLE && !shift_low) begin
            state_d    = IDLE;
            position_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    position_d = '0;
                    bit_cnt_d  = '0;
                    if (shift_low) begin
                        boot_mode_d = boot_low;
                        clk_div_d   = '0;
                        if (boot_low) begin
                            state_d      = BOOT_RUN;
                            page_start_d = 1'b1;
                        end else begin
                            state_d = USER_WAIT;
                        end
                    end
                end
                BOOT_RUN: begin
                    if (bit_cnt_q == POS_W'(BOOT_CYCLES)) begin
                        page_done_d = 1'b1;
                        state_d     = DONE;
                    end else if (tick) begin
                        bit_strobe_d = 1'b1;
                        position_d   = bit_cnt_q;
                        bit_cnt_d    = bit_cnt_q + POS_W'(1);
                    end
                end
                USER_WAIT: begin
                    if (rep_low) begin
                        rep_cnt_d = '0;
                        state_d   = REP;
                    end
                end
                REP: begin
                    if (rep_low) begin
                        if (rep_cnt_q < REP_W'(REP_MIN_CLKS)) rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end else if (rep_cnt_q >= REP_W'(REP_MIN_CLKS)) begin
                        clk_div_d = '0;
                        off_cnt_d = OFF_W'(DATA_OFFSET);
                        bit_cnt_d = '0;
                        state_d   = USER_RUN;
                    end else begin
                        state_d = USER_WAIT;
                    end
                end
                USER_RUN: begin
                    if (bit_cnt_q == POS_W'(PAGE_CYCLES)) begin
                        page_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // The window opens one clock before the tick that exhausts the offset,
                        // so the first data bit lands exactly DATA_OFFSET cycles after release.
                        if (off_cnt_q == OFF_W'(1) && pre_tick) page_start_d = 1'b1;
                        if (tick) begin
                            if (off_cnt_q != '0) off_cnt_d = off_cnt_q - OFF_W'(1);
                            if (off_cnt_q <= OFF_W'(1)) begin
                                bit_strobe_d = 1'b1;
                                position_d   = bit_cnt_q;
                                bit_cnt_d    = bit_cnt_q + POS_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (!boot_mode_q && rep_low) begin
                        rep_cnt_d = '0;
                        state_d   = REP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        access_active_d = (state_d != IDLE);
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            shift_sync_q    <= 2'b11;
            rep_sync_q      <= 2'b11;
            boot_sync_q     <= 2'b11;
            state_q         <= IDLE;
            clk_div_q       <= '0;
            bit_cnt_q       <= '0;
            rep_cnt_q       <= '0;
            off_cnt_q       <= '0;
            bit_strobe_q    <= 1'b0;
            position_q      <= '0;
            page_start_q    <= 1'b0;
            page_done_q     <= 1'b0;
            boot_mode_q     <= 1'b0;
            access_active_q <= 1'b0;
        end else begin
            shift_sync_q    <= shift_sync_d;
            rep_sync_q      <= rep_sync_d;
            boot_sync_q     <= boot_sync_d;
            state_q         <= state_d;
            clk_div_q       <= clk_div_d;
            bit_cnt_q       <= bit_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
            off_cnt_q       <= off_cnt_d;
            bit_strobe_q    <= bit_strobe_d;
            position_q      <= position_d;
            page_start_q    <= page_start_d;
            page_done_q     <= page_done_d;
            boot_mode_q     <= boot_mode_d;
            access_active_q <= access_active_d;
        end
    end

    assign bit_strobe    = bit_strobe_q;
    assign position      = position_q;
    assign page_start    = page_start_q;
    assign page_done     = page_done_q;
    assign boot_mode     = boot_mode_q;
    assign access_active = access_active_q;

`ifdef BUBBLE_TIMING_WATCHDOG_EN
    localparam int WD_W     = POS_W + 2;
    localparam int WD_LIMIT = 2 * PAGE_CYCLES;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timing_error_q, timing_error_d;
    logic            wd_watch;

    // Only user-mode waits expect a replicator pulse; boot DONE may idle forever.
    assign wd_watch = (state_q == USER_WAIT) || (state_q == DONE && !boot_mode_q);

    always_comb begin
        wd_cnt_d       = wd_cnt_q;
        timing_error_d = timing_error_q;
        if (state_q == IDLE || state_q == USER_RUN) begin
            wd_cnt_d = '0;
        end else if (wd_watch && tick && wd_cnt_q <= WD_W'(WD_LIMIT)) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (wd_cnt_q > WD_W'(WD_LIMIT)) timing_error_d = 1'b1;
        if (state_q == REP && state_d == USER_WAIT) timing_error_d = 1'b1;
        if (state_q != IDLE && state_d == IDLE) begin
            timing_error_d = 1'b0;
            wd_cnt_d       = '0;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            wd_cnt_q       <= '0;
            timing_error_q <= 1'b0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            timing_error_q <= timing_error_d;
        end
    end

    assign timing_error = timing_error_q;
`endif

endmodule

// File: tb/tb_bubble_timing_generator.sv
// Directed bench for bubble_timing_generator: timed stimulus pushes expected pulse events,
// a negedge monitor pops and compares every page_start / bit_strobe / page_done it sees.
module tb_bubble_timing_generator;

    localparam int POS_W = 13;
    localparam int EW    = 48;
    localparam logic [1:0] K_START = 2'd1;
    localparam logic [1:0] K_BIT   = 2'd2;
    localparam logic [1:0] K_DONE  = 2'd3;

    logic             clk;
    logic             reset;
    logic             shift_n;
    logic             rep_n;
    logic             boot_n;
    logic             bit_strobe;
    logic [POS_W-1:0] position;
    logic             page_start;
    logic             page_done;
    logic             boot_mode;
    logic             access_active;
`ifdef BUBBLE_TIMING_WATCHDOG_EN
    logic             timing_error;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [EW-1:0] exp_q[$];

    bubble_timing_generator #(
        .CYCLE_CLKS  (8),
        .REP_MIN_CLKS(4),
        .DATA_OFFSET (2),
        .PAGE_CYCLES (5),
        .BOOT_CYCLES (6),
        .POS_W       (POS_W)
    ) dut (
        .master_clock       (clk),
        .reset              (reset),
        .bubble_shift_enable(shift_n),
        .replicator_enable  (rep_n),
        .bootloop_enable    (boot_n),
        .bit_strobe         (bit_strobe),
        .position           (position),
        .page_start         (page_start),
        .page_done          (page_done),
        .boot_mode          (boot_mode),
        .access_active      (access_active)
`ifdef BUBBLE_TIMING_WATCHDOG_EN
        ,
        .timing_error       (timing_error)
`endif
    );

    // Clock and cycle counter: at a negedge, cyc equals the number of posedges so far.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic bm,
                                            input logic [POS_W-1:0] p, input int t);
        return {k, bm, p, 32'(t)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Boot access entered at e0: page_start at e0, strobes every 8 clocks, done one clock after the last.
    task automatic push_boot(input int e0);
        exp_q.push_back(mk_ev(K_START, 1'b1, '0, e0));
        for (int j = 0; j < 6; j++) exp_q.push_back(mk_ev(K_BIT, 1'b1, 13'(j), e0 + 8 + 8 * j));
        exp_q.push_back(mk_ev(K_DONE, 1'b1, '0, e0 + 49));
    endtask

    // User window released at e0: page_start at e0+15, first strobe at e0+16 (2 bubble cycles).
    task automatic push_user(input int e0, input int nbits, input bit full);
        exp_q.push_back(mk_ev(K_START, 1'b0, '0, e0 + 15));
        for (int j = 0; j < nbits; j++) exp_q.push_back(mk_ev(K_BIT, 1'b0, 13'(j), e0 + 16 + 8 * j));
        if (full) exp_q.push_back(mk_ev(K_DONE, 1'b0, '0, e0 + 49));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_strobe"}, int'(bit_strobe), 0);
        check({tag, "_position"}, int'(position), 0);
        check({tag, "_page_start"}, int'(page_start), 0);
        check({tag, "_page_done"}, int'(page_done), 0);
        check({tag, "_boot_mode"}, int'(boot_mode), 0);
        check({tag, "_access_active"}, int'(access_active), 0);
`ifdef BUBBLE_TIMING_WATCHDOG_EN
        check({tag, "_timing_error"}, int'(timing_error), 0);
`endif
    endtask

    // Monitor: every pulse the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] ev;
        logic [1:0]    k;
        int            n;
        if (bit_strobe === 1'b1 || page_start === 1'b1 || page_done === 1'b1) begin
            n = int'(bit_strobe === 1'b1) + int'(page_start === 1'b1) + int'(page_done === 1'b1);
            if (n > 1)                   k = 2'd0;
            else if (page_start === 1'b1) k = K_START;
            else if (bit_strobe === 1'b1) k = K_BIT;
            else                          k = K_DONE;
            obs = mk_ev(k, boot_mode, (k == K_BIT) ? position : '0, cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: got kind=%0d bm=%0d pos=%0d cyc=%0d expected none",
                         obs[47:46], obs[45], obs[44:32], obs[31:0]);
            end else begin
                ev = exp_q.pop_front();
                if (obs !== ev) begin
                    errors++;
                    $display("FAIL event: got kind=%0d bm=%0d pos=%0d cyc=%0d expected kind=%0d bm=%0d pos=%0d cyc=%0d",
                             obs[47:46], obs[45], obs[44:32], obs[31:0],
                             ev[47:46], ev[45], ev[44:32], ev[31:0]);
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        int e0;
        reset   = 1'b1;
        shift_n = 1'b1;
        rep_n   = 1'b1;
        boot_n  = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        goto(cyc + 2);

        // Boot access, bootloop_enable toggled mid-access.
        boot_n = 1'b0;
        goto(cyc + 3);
        shift_n = 1'b0;
        c  = cyc;
        e0 = c + 3;
        push_boot(e0);
        goto(e0 + 4);
        check("boot_active", int'(access_active), 1);
        check("boot_mode_set", int'(boot_mode), 1);
        goto(e0 + 20);
        boot_n = 1'b1;
        goto(e0 + 60);
        check("boot_mode_hold", int'(boot_mode), 1);
        goto(c + 100);
        shift_n = 1'b1;
        goto(c + 104);
        check("boot_release_active", int'(access_active), 0);
        check("boot_release_position", int'(position), 0);

        // User page, then a second pulse in DONE for a back-to-back page.
        goto(cyc + 4);
        shift_n = 1'b0;
        c = cyc;
        goto(c + 5);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 6);
        rep_n = 1'b1;
        e0 = r + 9;
        push_user(e0, 5, 1'b1);
        goto(e0 + 2);
        check("user_boot_mode", int'(boot_mode), 0);
        check("user_active", int'(access_active), 1);
        goto(e0 + 52);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 6);
        rep_n = 1'b1;
        e0 = r + 9;
        push_user(e0, 5, 1'b1);
        goto(e0 + 52);
        shift_n = 1'b1;
        goto(cyc + 5);
        check("user_release_active", int'(access_active), 0);

        // Glitches of 2 and 4 clocks are rejected; a 6-clock pulse then gives a full page.
        shift_n = 1'b0;
        c = cyc;
        goto(c + 6);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 2);
        rep_n = 1'b1;
        goto(r + 12);
`ifdef BUBBLE_TIMING_WATCHDOG_EN
        check("glitch_timing_error", int'(timing_error), 1);
`endif
        check("glitch_active", int'(access_active), 1);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 4);
        rep_n = 1'b1;
        goto(r + 12);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 6);
        rep_n = 1'b1;
        e0 = r + 9;
        push_user(e0, 5, 1'b1);
        goto(e0 + 52);
        shift_n = 1'b1;
        goto(cyc + 5);

        // Truncation: minimum-length (5-clock) pulse, release lands on the 4th strobe's tick.
        shift_n = 1'b0;
        c = cyc;
        goto(c + 6);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 5);
        rep_n = 1'b1;
        e0 = r + 8;
        push_user(e0, 3, 1'b0);
        goto(e0 + 37);
        shift_n = 1'b1;
        goto(e0 + 40);
        check("trunc_strobe_suppressed", int'(bit_strobe), 0);
        goto(e0 + 41);
        check("trunc_position", int'(position), 0);
        check("trunc_active", int'(access_active), 0);
        goto(e0 + 70);

        // Reset asserted on the edge that would carry the 3rd strobe.
        shift_n = 1'b0;
        c = cyc;
        goto(c + 6);
        r = cyc;
        rep_n = 1'b0;
        goto(r + 6);
        rep_n = 1'b1;
        e0 = r + 9;
        push_user(e0, 2, 1'b0);
        goto(e0 + 31);
        reset = 1'b1;
        goto(e0 + 32);
        check_all_zero("midreset");
        goto(e0 + 33);
        reset   = 1'b0;
        shift_n = 1'b1;
        goto(e0 + 80);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
